mem_access_ctrl: RTL and testbench

//  Load/store sequencer between the MEM pipeline stage and the 512x8 byte-addressed data RAM.
//  - Accepts one request at a time over a valid/ready handshake.
//  - Checks size and alignment, then drives the RAM's level-sensitive port with registered, glitch-free controls.
//  - Captures read data and sign/zero-extends it locally.
//  - Returns a one-cycle response pulse with data or an error flag.

---
 rtl/mem_access_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the MEM pipeline stage and a 512x8 byte-addressed data RAM.
// Requests are accepted one at a time over a valid/ready handshake. Each request is checked for
// size and alignment. A legal request then gets one cycle of address setup and one cycle of RAM
// enable. Read data is captured and extended locally. A one-cycle response pulse follows.
// The RAM-facing controls all come straight from flops so the level-sensitive port never sees
// a glitch.

module mem_access_ctrl #(
    parameter int unsigned AddrW = 9,
    parameter int unsigned DataW = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    // request side
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [1:0]       req_size_i,
    input  logic             req_signed_i,
    input  logic [AddrW-1:0] req_addr_i,
    input  logic [DataW-1:0] req_wdata_i,
    // response side
    output logic             resp_valid_o,
    output logic [DataW-1:0] resp_rdata_o,
    output logic             resp_error_o,
    // RAM side
    output logic             mem_enable_o,
    output logic             mem_read_write_o,
    output logic [1:0]       mem_size_o,
    output logic             mem_sign_extend_o,
    output logic [AddrW-1:0] mem_address_o,
    output logic [DataW-1:0] mem_data_in_o,
    input  logic [DataW-1:0] mem_data_out_i
);

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;
    localparam logic [1:0] SizeIll  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_e;

    state_e             state_q, state_d;

    // Latched request; doubles as the registered RAM control/address/data drive.
    logic               write_q, write_d;
    logic [1:0]         size_q, size_d;
    logic               signed_q, signed_d;
    logic [AddrW-1:0]   addr_q, addr_d;
    logic [DataW-1:0]   wdata_q, wdata_d;

    logic               en_q, en_d;
    logic               resp_valid_q, resp_valid_d;
    logic [DataW-1:0]   resp_rdata_q, resp_rdata_d;
    logic               resp_err_q, resp_err_d;

    logic               req_err;
    logic [DataW-1:0]   load_ext;

    // Size/alignment check on the incoming request.
    always_comb begin
        req_err = 1'b0;
        unique case (req_size_i)
            SizeByte: req_err = 1'b0;
            SizeHalf: req_err = req_addr_i[0];
            SizeWord: req_err = |req_addr_i[1:0];
            SizeIll:  req_err = 1'b1;
            default:  req_err = 1'b1;
        endcase
    end

    // Extend the RAM read data according to the latched size and signedness.
    always_comb begin
        load_ext = mem_data_out_i;
        unique case (size_q)
            SizeByte: begin
                load_ext = signed_q ? {{(DataW-8){mem_data_out_i[7]}}, mem_data_out_i[7:0]}
                                    : {{(DataW-8){1'b0}}, mem_data_out_i[7:0]};
            end
            SizeHalf: begin
                load_ext = signed_q ? {{(DataW-16){mem_data_out_i[15]}}, mem_data_out_i[15:0]}
                                    : {{(DataW-16){1'b0}}, mem_data_out_i[15:0]};
            end
            default: load_ext = mem_data_out_i;
        endcase
    end

    // Next-state logic. Response fields default to zero so they are only non-zero in RESP.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        en_d         = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    write_d  = req_write_i;
                    size_d   = req_size_i;
                    signed_d = req_signed_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    if (req_err) begin
                        // Skip the RAM entirely; answer with an error next cycle.
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                // Address/controls have been stable for one cycle; open the RAM.
                state_d = StAccess;
                en_d    = 1'b1;
            end
            StAccess: begin
                state_d      = StResp;
                resp_valid_d = 1'b1;
                if (!write_q) begin
                    resp_rdata_d = load_ext;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            en_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            en_q         <= en_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready_o       = (state_q == StIdle);
    assign resp_valid_o      = resp_valid_q;
    assign resp_rdata_o      = resp_rdata_q;
    assign resp_error_o      = resp_err_q;
    assign mem_enable_o      = en_q;
    assign mem_read_write_o  = write_q;
    assign mem_size_o        = size_q;
    assign mem_sign_extend_o = 1'b0;
    assign mem_address_o     = addr_q;
    assign mem_data_in_o     = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 512x8 RAM.
// The RAM reads combinationally with zero extension and writes on the clock edge.

module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic        mem_en, mem_rw, mem_sext;
    logic [1:0]  mem_size;
    logic [8:0]  mem_addr;
    logic [31:0] mem_din, mem_dout;

    int n_cmp = 0;
    int n_bad = 0;
    int en_cnt = 0;
    int resp_cnt = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .AddrW(9),
        .DataW(32)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_write_i      (req_write),
        .req_size_i       (req_size),
        .req_signed_i     (req_signed),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .resp_valid_o     (resp_valid),
        .resp_rdata_o     (resp_rdata),
        .resp_error_o     (resp_error),
        .mem_enable_o     (mem_en),
        .mem_read_write_o (mem_rw),
        .mem_size_o       (mem_size),
        .mem_sign_extend_o(mem_sext),
        .mem_address_o    (mem_addr),
        .mem_data_in_o    (mem_din),
        .mem_data_out_i   (mem_dout)
    );

    // Behavioural RAM, little-endian.
    logic [7:0] ram [512] = '{default: 8'h00};

    always_comb begin
        mem_dout = '0;
        case (mem_size)
            2'b00:   mem_dout = {24'h0, ram[mem_addr]};
            2'b01:   mem_dout = {16'h0, ram[mem_addr + 9'd1], ram[mem_addr]};
            default: mem_dout = {ram[mem_addr + 9'd3], ram[mem_addr + 9'd2],
                                 ram[mem_addr + 9'd1], ram[mem_addr]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_en && mem_rw) begin
            ram[mem_addr] <= mem_din[7:0];
            if (mem_size != 2'b00) ram[mem_addr + 9'd1] <= mem_din[15:8];
            if (mem_size == 2'b10) begin
                ram[mem_addr + 9'd2] <= mem_din[23:16];
                ram[mem_addr + 9'd3] <= mem_din[31:24];
            end
        end
    end

    // Count enable-high and response cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_en) en_cnt = en_cnt + 1;
        if (resp_valid) resp_cnt = resp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One request, called at a negedge; returns at the negedge where the response is seen.
    task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [8:0] a, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_rd);
        int waits;
        int lat;
        waits = 0;
        while (!req_ready && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        check({tag, " ready"}, req_ready, 1'b1);
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        en_cnt     = 0;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            if (mem_en) begin
                check({tag, " addr"}, mem_addr, a);
                check({tag, " rw"}, mem_rw, w);
                check({tag, " size"}, mem_size, sz);
                if (w) check({tag, " din"}, mem_din, wd);
            end
            if (resp_valid) lat = k;
            else @(negedge clk);
        end
        check({tag, " latency"}, lat, exp_err ? 32'd1 : 32'd3);
        check({tag, " rdata"}, resp_rdata, exp_rd);
        check({tag, " err"}, resp_error, exp_err);
        check({tag, " en cycles"}, en_cnt, exp_err ? 32'd0 : 32'd1);
        check({tag, " sext"}, mem_sext, 1'b0);
        if (!exp_err) check({tag, " addr hold"}, mem_addr, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        bw [3];
        logic [1:0]  bsz [3];
        logic [8:0]  ba [3];
        logic [31:0] bwd [3];
        logic [31:0] bexp [3];
        int          hs [3];
        int          acc, rsp, rc0;
        logic        hs_now;

        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst ready", req_ready, 1'b1);
        check("rst resp_valid", resp_valid, 1'b0);
        check("rst rdata", resp_rdata, 32'h0);
        check("rst err", resp_error, 1'b0);
        check("rst mem_en", mem_en, 1'b0);
        check("rst mem_rw", mem_rw, 1'b0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_din", mem_din, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Word store/load round trip
        do_req("st_w",  1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 1'b0, 32'h0);
        do_req("ld_w",  1'b0, 2'b10, 1'b0, 9'h010, 32'h0,        1'b0, 32'hDEADBEEF);

        // Reset while the RAM is enabled drops the request
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 9'h010;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("mid en high", mem_en, 1'b1);
        rc0 = resp_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid en low", mem_en, 1'b0);
        check("mid no resp", resp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid ready", req_ready, 1'b1);
        repeat (4) @(negedge clk);
        check("mid resp count", resp_cnt, rc0);

        // Byte at the top address
        do_req("st_b",  1'b1, 2'b00, 1'b0, 9'h1FF, 32'h000000F0, 1'b0, 32'h0);
        do_req("ld_sb", 1'b0, 2'b00, 1'b1, 9'h1FF, 32'h0,        1'b0, 32'hFFFFFFF0);
        do_req("ld_ub", 1'b0, 2'b00, 1'b0, 9'h1FF, 32'h0,        1'b0, 32'h000000F0);

        // Halfword
        do_req("st_h",  1'b1, 2'b01, 1'b0, 9'h020, 32'h00008001, 1'b0, 32'h0);
        do_req("ld_sh", 1'b0, 2'b01, 1'b1, 9'h020, 32'h0,        1'b0, 32'hFFFF8001);
        do_req("ld_uh", 1'b0, 2'b01, 1'b0, 9'h020, 32'h0,        1'b0, 32'h00008001);

        // Errors: misaligned word, misaligned half, illegal size
        do_req("e_w",   1'b0, 2'b10, 1'b0, 9'h013, 32'h0, 1'b1, 32'h0);
        do_req("e_h",   1'b0, 2'b01, 1'b1, 9'h021, 32'h0, 1'b1, 32'h0);
        do_req("e_sz",  1'b1, 2'b11, 1'b0, 9'h000, 32'h55AA55AA, 1'b1, 32'h0);
        check("err left ram", {ram[3], ram[2], ram[1], ram[0]}, 32'h0);

        // Back-to-back with valid held high
        bw[0] = 1'b1; bsz[0] = 2'b10; ba[0] = 9'h040; bwd[0] = 32'h12345678; bexp[0] = 32'h0;
        bw[1] = 1'b0; bsz[1] = 2'b10; ba[1] = 9'h040; bwd[1] = 32'h0;        bexp[1] = 32'h12345678;
        bw[2] = 1'b0; bsz[2] = 2'b00; ba[2] = 9'h043; bwd[2] = 32'h0;        bexp[2] = 32'h00000012;
        @(negedge clk);
        acc = 0; rsp = 0;
        hs[0] = 0; hs[1] = 0; hs[2] = 0;
        req_write = bw[0]; req_size = bsz[0]; req_signed = 1'b0;
        req_addr = ba[0]; req_wdata = bwd[0];
        req_valid = 1'b1;
        for (int c = 0; c < 40 && rsp < 3; c++) begin
            if (resp_valid) begin
                check("b2b rdata", resp_rdata, bexp[rsp]);
                check("b2b err", resp_error, 1'b0);
                rsp++;
            end
            hs_now = req_ready && req_valid;
            if (hs_now) begin
                hs[acc] = c;
                acc++;
            end
            @(negedge clk);
            if (hs_now) begin
                if (acc < 3) begin
                    req_write = bw[acc]; req_size = bsz[acc];
                    req_addr = ba[acc]; req_wdata = bwd[acc];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        check("b2b accepted", acc, 32'd3);
        check("b2b responses", rsp, 32'd3);
        check("b2b gap 0-1", hs[1] - hs[0], 32'd4);
        check("b2b gap 1-2", hs[2] - hs[1], 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
